c1541_sd_arb: RTL
=================

# c1541_sd_arb

Shares the single MiSTer SD block-request port (sd_lba/sd_rd/sd_wr/sd_ack plus the sd_buff byte bus) between up to four c1541_sd drive instances, so drives 8–11 can be mounted at the same time. It sits between the per-drive c1541_sd blocks and the HPS-side SD interface. One block transfer is in flight at a time. Grants are round-robin, and each grant is held until the host completes the transfer.

## Interface
Parameters:
- NDRV, 2, number of drive requesters (legal 1–4).

Ports:
- clk32  in  1  system clock.
- reset  in  1  synchronous, active-high.
- drv_lba  in  32*NDRV  per-drive LBA; slice i = [32*i+31:32*i].
- drv_rd  in  NDRV  per-drive read request (level, held until the drive sees its ack).
- drv_wr  in  NDRV  per-drive write request (level).
- drv_ack  out  NDRV  per-drive ack.
- drv_buff_din  in  8*NDRV  per-drive write data toward the host.
- drv_buff_wr  out  NDRV  per-drive buffer write strobe.
- sd_lba  out  32  LBA to the host.
- sd_rd  out  1  read request to the host.
- sd_wr  out  1  write request to the host.
- sd_ack  in  1  host ack.
- sd_buff_wr  in  1  host buffer write strobe.
- sd_buff_din  out  8  muxed write data to the host.
- grant_vld  out  1  a drive currently owns the port.
- grant_idx  out  2  index of the owning drive.

sd_buff_addr and sd_buff_dout are broadcast to all drives outside this block.

## Operation
States:
- IDLE
  - Wait for sd_ack=0. This covers an ack still high after reset or a cancel.
  - Then scan drv_rd|drv_wr starting at last+1 (mod NDRV) and pick the first active drive g.
  - Latch lba_r=drv_lba[g], rd_r=drv_rd[g], wr_r=drv_wr[g], grant=g, and go to REQ.
  - No requester active: stay in IDLE.
- REQ
  - sd_rd=rd_r, sd_wr=wr_r, sd_lba=lba_r.
  - sd_ack=1: go to BUSY.
  - Cancel: drv_rd[g]|drv_wr[g]=0 with sd_ack=0 returns to IDLE, with last unchanged.
- BUSY
  - sd_rd=sd_wr=0; sd_lba held.
  - sd_ack=0: set last=g and go to IDLE.
- Ack routing: drv_ack[g]=sd_ack while in REQ or BUSY, else 0. Non-granted drives always see drv_ack=0.
- Buffer write routing: drv_buff_wr[g]=sd_buff_wr in BUSY only; all other bits 0.
- Write data: sd_buff_din=drv_buff_din[g] while grant_vld, else 8'h00.
- Both drv_rd and drv_wr high on one drive: both are latched and forwarded unchanged. The arbiter does not resolve the conflict.
- Requests that arrive during REQ or BUSY are not latched. They are sampled at the next IDLE scan, and the drive keeps its level request until then.
- grant_idx wraps 3→0 for NDRV=4. For NDRV=1 it is always 0.

## Timing
- Reset values:
  - state=IDLE, sd_rd=0, sd_wr=0, sd_lba=0.
  - grant_vld=0, grant_idx=0, last=NDRV-1 (the first scan starts at drive 0).
  - drv_ack=0, drv_buff_wr=0, sd_buff_din=0.
- Reset mid-transfer aborts at once. In IDLE after reset, no grant is issued until sd_ack is sampled 0.
- Grant latency: a request first sampled in IDLE at edge t drives sd_rd/sd_wr/sd_lba on the output registers from edge t+1.
- sd_rd/sd_wr fall on the edge after sd_ack is sampled high.
- drv_ack, drv_buff_wr and sd_buff_din are combinational from the registered grant and state. They have zero added latency, so the per-byte sd_buff timing is unchanged.
- Back-to-back grants: after sd_ack falls there is one IDLE cycle before the next REQ. Minimum gap is 2 cycles from sd_ack low to the next sd_rd/sd_wr.
- sd_lba is stable from REQ entry until the BUSY exit.

## Structure
- Shared package/include c1541_pkg holds:
  - state encodings ST_IDLE/ST_REQ/ST_BUSY;
  - MAX_DRV=4.
- Sub-module c1541_rr_pick: combinational round-robin picker.
  - Inputs: req[NDRV-1:0], last[1:0].
  - Outputs: idx[1:0], any.
- Top level holds the FSM, the latches and the output muxes.

## Test plan
- Single read: drive 0 asserts rd with lba=0x00000123.
  - Next cycle: sd_rd=1, sd_lba=0x123.
  - Host ack high for 514 cycles with 512 sd_buff_wr pulses.
  - Required: drv_buff_wr[0] gets all 512 pulses, drv_buff_wr[1] gets none.
  - Required: drv_ack[0] follows sd_ack; grant_vld drops 1 cycle after ack falls.
- Contention: drives 0 and 1 both request in the same cycle after reset.
  - Drive 0 is served first, then drive 1. Both hold rd throughout.
  - Then drive 0 requests again alone: it is granted, confirming last=1 leads back to 0.
- Write path: drive 1 writes with lba=0x40, drv_buff_din slice 1 = 0xA5.
  - Required: sd_wr=1 and sd_buff_din=0xA5 during BUSY.
  - Required: drv_ack[0]=0 throughout.
- Cancel: drive 0 drops rd while in REQ before any ack.
  - Required: return to IDLE, sd_rd=0 the next cycle, last unchanged.
  - Required: a pending drive-1 request is granted next.
- Reset mid-transfer: assert reset during BUSY with sd_ack still high.
  - Required: all outputs return to reset values.
  - Required: a new request is not granted until sd_ack is sampled 0.
- NDRV=4 fairness: all four drives request continuously for 8 transfers.
  - Required grant order: 0,1,2,3,0,1,2,3.

Source files
------------

// File: rtl/c1541_pkg.sv
// c1541_pkg: shared definitions for the multi-drive SD arbiter.
// Provides the arbiter FSM state encoding and the maximum drive count.
package c1541_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_BUSY = 2'd2
    } state_t;

    localparam int MAX_DRV = 4;

endpackage

// File: rtl/c1541_rr_pick.sv
// c1541_rr_pick: combinational round-robin picker.
// Ports:
//   req  - per-drive active request (rd|wr)
//   last - index of the most recently served drive
//   idx  - first active drive found scanning from last+1 (mod NDRV)
//   any  - at least one request is active
module c1541_rr_pick #(
    parameter int NDRV = 2
) (
    input  logic [NDRV-1:0] req,
    input  logic [1:0]      last,
    output logic [1:0]      idx,
    output logic            any
);

    // Scan offsets from NDRV down to 1 so the closest drive after last wins.
    // Unrolling over each possible last value keeps all selects constant.
    always_comb begin
        idx = 2'd0;
        any = 1'b0;
        for (int j = 0; j < NDRV; j++) begin
            if (last == 2'(j)) begin
                for (int k = NDRV; k >= 1; k--) begin
                    if (req[(j + k) % NDRV]) begin
                        idx = 2'((j + k) % NDRV);
                        any = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/c1541_sd_arb.sv
// c1541_sd_arb: shares one host SD block-request port between up to four drives.
// Ports:
//   clk32, reset         - clock, synchronous active-high reset
//   drv_lba/rd/wr        - per-drive block requests (level)
//   drv_ack, drv_buff_wr - per-drive ack and buffer write strobe, routed to the owner
//   drv_buff_din         - per-drive write data, muxed to sd_buff_din
//   sd_lba/rd/wr, sd_ack - host-side request/ack
//   sd_buff_wr           - host buffer write strobe
//   grant_vld, grant_idx - current owner of the port
module c1541_sd_arb
    import c1541_pkg::*;
#(
    parameter int NDRV = 2
) (
    input  logic              clk32,
    input  logic              reset,
    input  logic [32*NDRV-1:0] drv_lba,
    input  logic [NDRV-1:0]   drv_rd,
    input  logic [NDRV-1:0]   drv_wr,
    output logic [NDRV-1:0]   drv_ack,
    input  logic [8*NDRV-1:0] drv_buff_din,
    output logic [NDRV-1:0]   drv_buff_wr,
    output logic [31:0]       sd_lba,
    output logic              sd_rd,
    output logic              sd_wr,
    input  logic              sd_ack,
    input  logic              sd_buff_wr,
    output logic [7:0]        sd_buff_din,
    output logic              grant_vld,
    output logic [1:0]        grant_idx
);

    state_t      state_q, state_d;
    logic [1:0]  last_q, last_d;
    logic [1:0]  grant_q, grant_d;
    logic [31:0] lba_q, lba_d;
    logic        rd_q, rd_d, wr_q, wr_d;
    logic        sd_rd_q, sd_rd_d, sd_wr_q, sd_wr_d;
    logic [1:0]  pick_idx;
    logic        pick_any;
    logic        sel_req;
    logic [7:0]  sel_din;
    logic [31:0] pick_lba;
    logic        pick_rd, pick_wr;

    c1541_rr_pick #(.NDRV(NDRV)) u_pick (
        .req  (drv_rd | drv_wr),
        .last (last_q),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    // Per-drive muxes for the current owner and the scan candidate.
    always_comb begin
        sel_req  = 1'b0;
        sel_din  = 8'h00;
        pick_lba = 32'h0;
        pick_rd  = 1'b0;
        pick_wr  = 1'b0;
        for (int i = 0; i < NDRV; i++) begin
            if (grant_q == 2'(i)) begin
                sel_req = drv_rd[i] | drv_wr[i];
                sel_din = drv_buff_din[8*i +: 8];
            end
            if (pick_idx == 2'(i)) begin
                pick_lba = drv_lba[32*i +: 32];
                pick_rd  = drv_rd[i];
                pick_wr  = drv_wr[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_d = grant_q;
        lba_d   = lba_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        case (state_q)
            // A lingering host ack (after reset or a cancel) blocks new grants.
            ST_IDLE: if (!sd_ack && pick_any) begin
                state_d = ST_REQ;
                grant_d = pick_idx;
                lba_d   = pick_lba;
                rd_d    = pick_rd;
                wr_d    = pick_wr;
            end
            // Host ack wins over a same-cycle cancel; a cancel leaves last alone.
            ST_REQ:  state_d = sd_ack ? ST_BUSY : (sel_req ? ST_REQ : ST_IDLE);
            ST_BUSY: if (!sd_ack) begin
                state_d = ST_IDLE;
                last_d  = grant_q;
            end
            default: state_d = ST_IDLE;
        endcase
        sd_rd_d = (state_d == ST_REQ) && rd_d;
        sd_wr_d = (state_d == ST_REQ) && wr_d;
    end

    always_ff @(posedge clk32) begin
        if (reset) begin
            state_q <= ST_IDLE;
            last_q  <= 2'(NDRV - 1);
            grant_q <= 2'd0;
            lba_q   <= 32'h0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            sd_rd_q <= 1'b0;
            sd_wr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            lba_q   <= lba_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            sd_rd_q <= sd_rd_d;
            sd_wr_q <= sd_wr_d;
        end
    end

    assign grant_vld   = state_q != ST_IDLE;
    assign grant_idx   = grant_q;
    assign sd_lba      = lba_q;
    assign sd_rd       = sd_rd_q;
    assign sd_wr       = sd_wr_q;
    assign sd_buff_din = grant_vld ? sel_din : 8'h00;

    // Ack and byte strobes go straight through so per-byte timing is untouched.
    always_comb begin
        drv_ack     = '0;
        drv_buff_wr = '0;
        for (int i = 0; i < NDRV; i++) begin
            drv_ack[i]     = grant_vld && grant_q == 2'(i) && sd_ack;
            drv_buff_wr[i] = state_q == ST_BUSY && grant_q == 2'(i) && sd_buff_wr;
        end
    end

endmodule
